// File: rtl/qdma_h2c_axis_checker.sv
// qdma_h2c_axis_checker: H2C AXI-Stream sink checking parity, 16-bit incrementing pattern, tkeep and qid, with saturating pkt/beat/byte counters
module qdma_h2c_axis_checker #(
  parameter int DATA_W = 512,
  parameter int TUSR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic                chk_en,
  input  logic                chk_clr,
  input  logic [10:0]         exp_qid,
  input  logic [CNT_W-1:0]    num_pkts,
  input  logic                throttle_en,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tparity,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic [TUSR_W-1:0]   s_tusr,
  output logic                s_tready,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic [CNT_W-1:0]    byte_cnt,
  output logic                err_parity,
  output logic                err_data,
  output logic                err_keep,
  output logic                err_qid,
  output logic                done
);
  localparam int KW = DATA_W / 8;
  localparam int NW = DATA_W / 16;
  localparam int PW = $clog2(KW + 1);
  localparam logic [1:0] IDLE = 2'd0, SOP = 2'd1, BODY = 2'd2, DONE = 2'd3;
  logic [1:0] state, state_nx, thr;
  logic [15:0] widx, base;
  logic acc, hit, e_par, e_dat, e_keep, e_qid, unused_tusr;
  logic [PW-1:0] pc;
  logic [CNT_W:0] bsum;
  logic [CNT_W-1:0] pkt_nx;
  always_comb begin
    unused_tusr = ^s_tusr[TUSR_W-1:11];
    acc = s_tvalid & s_tready;
    base = state == SOP ? 16'd0 : widx;
    pkt_nx = &pkt_cnt ? pkt_cnt : pkt_cnt + CNT_W'(1);
    hit = num_pkts != '0 && pkt_nx == num_pkts;
    e_par = 1'b0;
    e_dat = 1'b0;
    pc = '0;
    e_keep = s_tkeep == '0 || (s_tlast ? (s_tkeep & (s_tkeep + KW'(1))) != '0 : s_tkeep != '1);
    for (int i = 0; i < KW; i++) begin
      e_par |= s_tkeep[i] & (s_tparity[i] ^ (^s_tdata[8*i+:8]));
      pc += PW'(s_tkeep[i]);
    end
    for (int i = 0; i < NW; i++) begin
      e_keep |= s_tkeep[2*i] ^ s_tkeep[2*i+1];
      e_dat |= s_tkeep[2*i] & s_tkeep[2*i+1] & (s_tdata[16*i+:16] != base + 16'(i));
    end
    e_qid = state == SOP && s_tusr[10:0] != exp_qid;
    bsum = {1'b0, byte_cnt} + (CNT_W+1)'(pc);
    state_nx = state == IDLE ? (chk_en ? SOP : IDLE) :
               state == DONE ? DONE :
               acc && s_tlast ? (hit ? DONE : (state == SOP && !chk_en ? IDLE : SOP)) :
               acc ? BODY :
               state == SOP && !chk_en ? IDLE : state;
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn || chk_clr) begin
      state <= IDLE;
      thr <= '0;
      widx <= '0;
      s_tready <= 1'b0;
      pkt_cnt <= '0;
      beat_cnt <= '0;
      byte_cnt <= '0;
      err_parity <= 1'b0;
      err_data <= 1'b0;
      err_keep <= 1'b0;
      err_qid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      thr <= thr + 2'd1;
      s_tready <= (state_nx == SOP || state_nx == BODY) && !(throttle_en && thr == 2'd2);
      if (acc) begin
        widx <= s_tlast ? 16'd0 : base + 16'(NW);
        beat_cnt <= &beat_cnt ? beat_cnt : beat_cnt + CNT_W'(1);
        byte_cnt <= bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
        err_parity <= err_parity | e_par;
        err_data <= err_data | e_dat;
        err_keep <= err_keep | e_keep;
        err_qid <= err_qid | e_qid;
        if (s_tlast) begin
          pkt_cnt <= pkt_nx;
          done <= done | hit;
        end
      end
    end
  end
endmodule

// File: tb/tb_qdma_h2c_axis_checker.sv
// tb_qdma_h2c_axis_checker: directed self-checking bench for the H2C stream checker
module tb_qdma_h2c_axis_checker;
  logic clk = 1'b0;
  logic aresetn, chk_en, chk_clr, throttle_en;
  logic [10:0] exp_qid;
  logic [31:0] num_pkts;
  logic [511:0] s_tdata;
  logic [63:0] s_tparity, s_tkeep, s_tusr;
  logic s_tlast, s_tvalid, s_tready;
  logic [31:0] pkt_cnt, beat_cnt, byte_cnt;
  logic err_parity, err_data, err_keep, err_qid, done;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  qdma_h2c_axis_checker dut (
    .axi_aclk(clk), .axi_aresetn(aresetn), .chk_en(chk_en), .chk_clr(chk_clr),
    .exp_qid(exp_qid), .num_pkts(num_pkts), .throttle_en(throttle_en),
    .s_tdata(s_tdata), .s_tparity(s_tparity), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tkeep(s_tkeep), .s_tusr(s_tusr), .s_tready(s_tready),
    .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt), .byte_cnt(byte_cnt),
    .err_parity(err_parity), .err_data(err_data), .err_keep(err_keep), .err_qid(err_qid),
    .done(done)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [511:0] pat(input int b);
    logic [511:0] d;
    for (int j = 0; j < 32; j++) d[16*j+:16] = 16'(b + j);
    return d;
  endfunction
  function automatic logic [63:0] par(input logic [511:0] d);
    logic [63:0] p;
    for (int i = 0; i < 64; i++) p[i] = ^d[8*i+:8];
    return p;
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l,
                      input logic [10:0] q, input logic [63:0] pf);
    int n = 0;
    s_tdata = d;
    s_tparity = par(d) ^ pf;
    s_tkeep = k;
    s_tlast = l;
    s_tusr = {53'd0, q};
    s_tvalid = 1'b1;
    while (!s_tready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed_tready=0 expected_tready=1");
    end else begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
  endtask
  task automatic clear();
    chk_clr = 1'b1;
    step(1);
    chk_clr = 1'b0;
  endtask
  initial begin
    logic [511:0] d;
    logic a;
    int nacc;
    aresetn = 1'b0; chk_en = 1'b0; chk_clr = 1'b0; throttle_en = 1'b0;
    exp_qid = 11'd5; num_pkts = 32'd2;
    s_tdata = '0; s_tparity = '0; s_tkeep = '0; s_tusr = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    step(3);
    chk("rst_tready", s_tready, 0);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_byte", byte_cnt, 0);
    chk("rst_flags", {err_parity, err_data, err_keep, err_qid, done}, 0);
    aresetn = 1'b1;
    chk_en = 1'b1;
    step(1);
    for (int p = 0; p < 2; p++) begin
      send(pat(0), '1, 1'b0, 11'd5, '0);
      send(pat(32), '1, 1'b0, 11'd5, '0);
      send(pat(64), 64'h0000_FFFF_FFFF_FFFF, 1'b1, 11'd5, '0);
    end
    step(3);
    chk("t1_pkt", pkt_cnt, 2);
    chk("t1_beat", beat_cnt, 6);
    chk("t1_byte", byte_cnt, 2 * (2 * 64 + 48));
    chk("t1_errs", {err_parity, err_data, err_keep, err_qid}, 0);
    chk("t1_done", done, 1);
    chk("t1_tready", s_tready, 0);
    num_pkts = 32'd0;
    clear();
    chk("clr_beat", beat_cnt, 0);
    chk("clr_done", done, 0);
    send(pat(0), '1, 1'b1, 11'd5, 64'h80);
    chk("t2_flags", {err_parity, err_data, err_keep, err_qid}, 4'b1000);
    send(pat(0), '1, 1'b1, 11'd5, '0);
    chk("t2_sticky", {err_parity, err_data, err_keep, err_qid}, 4'b1000);
    chk("t2_pkt", pkt_cnt, 2);
    clear();
    chk("t2_clr", err_parity, 0);
    d = pat(32);
    d[16*8+:16] = 16'hBEEF;
    send(pat(0), '1, 1'b0, 11'd5, '0);
    send(d, '1, 1'b1, 11'd5, '0);
    chk("t3_data", {err_parity, err_data, err_keep, err_qid}, 4'b0100);
    clear();
    send(pat(0), '1, 1'b1, 11'd6, '0);
    chk("t3_qid", {err_parity, err_data, err_keep, err_qid}, 4'b0001);
    clear();
    send(pat(0), 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 11'd5, '0);
    send(pat(32), '1, 1'b1, 11'd5, '0);
    chk("t4_keep_body", {err_parity, err_data, err_keep, err_qid}, 4'b0010);
    clear();
    send(pat(0), 64'h0F0, 1'b1, 11'd5, '0);
    chk("t4_keep_last", {err_parity, err_data, err_keep, err_qid}, 4'b0010);
    chk("t4_byte", byte_cnt, 4);
    clear();
    throttle_en = 1'b1;
    step(2);
    nacc = 0;
    s_tkeep = '1; s_tlast = 1'b0; s_tusr = 64'd5;
    for (int c = 0; c < 40; c++) begin
      s_tdata = pat(32 * nacc);
      s_tparity = par(s_tdata);
      s_tvalid = 1'b1;
      a = s_tready;
      step(1);
      if (a) nacc++;
    end
    s_tvalid = 1'b0;
    chk("t5_nacc", 64'(nacc), 30);
    chk("t5_beat", beat_cnt, 30);
    chk("t5_byte", byte_cnt, 30 * 64);
    chk("t5_flags", {err_parity, err_data, err_keep, err_qid}, 0);
    throttle_en = 1'b0;
    clear();
    for (int i = 0; i < 2100; i++) send(pat(32 * i), '1, i == 2099, 11'd5, '0);
    chk("t6_beat", beat_cnt, 2100);
    chk("t6_pkt", pkt_cnt, 1);
    chk("t6_byte", byte_cnt, 2100 * 64);
    chk("t6_flags", {err_parity, err_data, err_keep, err_qid}, 0);
    for (int i = 0; i < 5; i++) send(pat(32 * i), '1, 1'b0, 11'd5, '0);
    chk("t6_mid_beat", beat_cnt, 2105);
    clear();
    chk("t6_clr_beat", beat_cnt, 0);
    chk("t6_clr_pkt", pkt_cnt, 0);
    chk("t6_clr_byte", byte_cnt, 0);
    chk("t6_clr_tready", s_tready, 0);
    step(2);
    chk("sim_ready", s_tready, 1);
    s_tdata = pat(0); s_tparity = par(s_tdata); s_tlast = 1'b1; s_tvalid = 1'b1;
    chk_clr = 1'b1;
    step(1);
    chk_clr = 1'b0; s_tvalid = 1'b0;
    chk("sim_clr_beat", beat_cnt, 0);
    chk_en = 1'b0;
    step(3);
    chk("dis_tready", s_tready, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
